// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring shift-subtract step per cycle.
// Divide-by-zero and signed overflow bypass the iteration and finish on the next edge.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [2:0]      op_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] hi_q, lo_q, opnd_q, result_q;
  logic            neg_q;

  // Operand decode, only meaningful while idle
  logic            a_signed, b_signed, neg_a, neg_b, div_zero, div_ovf, special;
  logic [XLEN-1:0] mag_a, mag_b, special_res;

  always_comb begin
    a_signed    = op[2] ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
    b_signed    = op[2] ? ~op[0] : (op[1:0] == 2'b01);
    neg_a       = a_signed & a[XLEN-1];
    neg_b       = b_signed & b[XLEN-1];
    mag_a       = neg_a ? -a : a;
    mag_b       = neg_b ? -b : b;
    div_zero    = op[2] & (b == '0);
    div_ovf     = op[2] & ~op[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
    special     = div_zero | div_ovf;
    special_res = div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);
  end

  // One iteration step; lo holds multiplier (mul) or dividend/quotient (div)
  logic [XLEN:0]     add_sum, shifted, trial;
  logic              qbit, last;
  logic [XLEN-1:0]   hi_n, lo_n, quo_s, rem_s, final_res;
  logic [2*XLEN-1:0] prod_s;

  always_comb begin
    add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    shifted = {hi_q, lo_q[XLEN-1]};
    trial   = shifted - {1'b0, opnd_q};
    qbit    = ~trial[XLEN];
    if (op_q[2]) begin
      hi_n = qbit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
      lo_n = {lo_q[XLEN-2:0], qbit};
    end else begin
      hi_n = add_sum[XLEN:1];
      lo_n = {add_sum[0], lo_q[XLEN-1:1]};
    end
    prod_s = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
    quo_s  = neg_q ? -lo_n : lo_n;
    rem_s  = neg_q ? -hi_n : hi_n;
    if (op_q[2])               final_res = op_q[1] ? rem_s : quo_s;
    else if (op_q[1:0] == '0)  final_res = prod_s[XLEN-1:0];
    else                       final_res = prod_s[2*XLEN-1:XLEN];
    last = (cnt_q == CW'(XLEN - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = special ? StDone : StBusy;
      StBusy:  if (last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StBusy);
    done = (state_q == StDone);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: if (start) begin
          op_q   <= op;
          cnt_q  <= '0;
          hi_q   <= '0;
          lo_q   <= op[2] ? mag_a : mag_b;
          opnd_q <= op[2] ? mag_b : mag_a;
          // Remainder takes the dividend's sign; everything else the product of signs
          neg_q  <= (op[2] & op[1]) ? neg_a : (neg_a ^ neg_b);
          if (special) result_q <= special_res;
        end
        StBusy: begin
          hi_q  <= hi_n;
          lo_q  <= lo_n;
          cnt_q <= cnt_q + CW'(1);
          if (last) result_q <= final_res;
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomised checks of muldiv_unit against an arithmetic reference model,
// with expected results queued at launch and compared when done pulses.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    logic [63:0] p;
    logic        ovf;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
      3'd1: begin p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y}); return p[63:32]; end
      3'd2: begin p = $signed({{32{x[31]}}, x}) * $signed({32'b0, y}); return p[63:32]; end
      3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
      3'd4: return (y == 0) ? 32'hFFFF_FFFF : ovf ? x : 32'($signed(x) / $signed(y));
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: return (y == 0) ? x : ovf ? 32'h0 : 32'($signed(x) % $signed(y));
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] o, input logic [31:0] x,
                                   input logic [31:0] y);
    if (o[2] && (y == 0)) return 1;
    if (o[2] && !o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Called at a negedge while the DUT is idle
  task automatic launch(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp, input int lat);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    sb_q.push_back('{tag, exp, lat});
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Waits for done (bounded), optionally pulsing a stray start at sample inject_at
  task automatic finish_op(input int inject_at);
    int   n = 41;
    int   busy_cnt = 0;
    exp_t e;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      check("busy_done_excl", {31'b0, busy & done}, 32'h0);
      if (done) begin
        n = i;
        break;
      end
      if (busy) busy_cnt++;
      start = (i == inject_at);
      if (i == inject_at) begin
        op = 3'b101;
        a  = 32'd100;
        b  = 32'd7;
      end
    end
    start = 1'b0;
    e = sb_q.pop_front();
    check({e.tag, "_lat"}, 32'(n), 32'(e.lat));
    check({e.tag, "_busy"}, 32'(busy_cnt), 32'(e.lat - 1));
    check(e.tag, result, e.exp);
    @(negedge clk);
    check({e.tag, "_hold"}, result, e.exp);
    check({e.tag, "_pulse"}, {31'b0, done}, 32'h0);
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] exp, input int lat);
    launch(tag, o, x, y, exp, lat);
    finish_op(0);
  endtask

  initial begin
    exp_t        dropped;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    reset = 1'b1;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_result", result, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    run("mul_7x6", 3'd0, 32'd7, 32'd6, 32'd42, 33);
    run("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    run("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run("mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33);
    run("mul_b0", 3'd0, 32'd12345, 32'd0, 32'd0, 33);
    run("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, 33);
    run("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2, 33);
    run("div_by0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run("rem_by0", 3'd6, 32'd5, 32'd0, 32'd5, 1);
    run("divu_by0", 3'd5, 32'd9, 32'd0, 32'hFFFF_FFFF, 1);
    run("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

    // Stray start while busy must not disturb the op in flight
    launch("mul_ignore", 3'd0, 32'd7, 32'd6, 32'd42, 33);
    finish_op(5);

    // Reset mid-divide discards the op and clears outputs immediately
    launch("divu_rst", 3'd5, 32'd1000, 32'd3, 32'd333, 33);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'h0);
    check("midrst_done", {31'b0, done}, 32'h0);
    check("midrst_result", result, 32'h0);
    dropped = sb_q.pop_front();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run("divu_after_rst", 3'd5, 32'd1000, 32'd3, 32'd333, 33);

    for (int i = 0; i < 10; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : (i == 5) ? 32'hFFFF_FFFF : $urandom;
      if (i == 7) rb = 32'($urandom_range(1, 100));
      run($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, model(ro, ra, rb),
          model_lat(ro, ra, rb));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
